stopwatch_controller: RTL and testbench

- Sequencing FSM for a cascaded chain of Generic decimal counter stages (units → tens → …) on the CMOD-A7 counter design.
- Converts raw start/stop and clear buttons into start, pause, clear and terminal-count control.
- Generates the prescaled count-enable tick, the chain reset and the count direction.
- Reports run/done status to LEDs.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/btn_edge_sync.sv | 28 ++
 rtl/stopwatch_controller.sv | 115 +++++++++++
 tb/tb_stopwatch_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and prescale defaults for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Short period keeps simulation fast; board value gives a 1 kHz tick at 100 MHz.
  localparam int PRESCALE_MAX_SIM   = 3;
  localparam int PRESCALE_MAX_BOARD = 99_999;

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop synchronizer followed by a registered rising-edge pulse
module btn_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic pulse
);

  logic sync0;
  logic sync1;
  logic prev;

  // Pulse is registered so it lags the raw input by three clock edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      prev  <= sync1;
      pulse <= sync1 & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/clear sequencing and tick generation for a decimal counter chain
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE_MAX   = 99_999,
  parameter int PRESCALE_WIDTH = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_START_STOP,
  input  logic       BTN_CLEAR,
  input  logic       MODE_DOWN,
  input  logic       ZERO_DETECT,
  input  logic       CHAIN_TRIG,
  output logic       CNT_ENABLE,
  output logic       CNT_RESET,
  output logic       CNT_DIR,
  output logic       RUNNING,
  output logic       EXPIRED,
  output logic [1:0] STATE
);

  localparam logic [PRESCALE_WIDTH-1:0] PS_MAX = PRESCALE_WIDTH'(PRESCALE_MAX);

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic                      start_edge;
  logic                      clr_edge;
  logic                      terminal;

  btn_edge_sync u_start_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (BTN_START_STOP),
    .pulse (start_edge)
  );

  btn_edge_sync u_clear_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (BTN_CLEAR),
    .pulse (clr_edge)
  );

  assign terminal = CNT_DIR ? ZERO_DETECT : CHAIN_TRIG;
  assign STATE    = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      prescaler  <= '0;
      CNT_ENABLE <= 1'b0;
      CNT_RESET  <= 1'b1;
      CNT_DIR    <= 1'b0;
      RUNNING    <= 1'b0;
      EXPIRED    <= 1'b0;
    end else begin
      CNT_ENABLE <= 1'b0;
      CNT_RESET  <= 1'b0;
      case (state)
        IDLE: begin
          prescaler <= '0;
          CNT_DIR   <= MODE_DOWN;
          // A direction change reloads the chain with its new starting value.
          if (clr_edge || (MODE_DOWN != CNT_DIR)) CNT_RESET <= 1'b1;
          if (!clr_edge && start_edge) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end
        end
        RUN: begin
          if (clr_edge) begin
            state     <= IDLE;
            RUNNING   <= 1'b0;
            prescaler <= '0;
            CNT_RESET <= 1'b1;
          end else if (terminal) begin
            state   <= DONE;
            RUNNING <= 1'b0;
            EXPIRED <= 1'b1;
          end else if (start_edge) begin
            // Prescaler holds, so a tick due on this cycle is issued after resume.
            state   <= PAUSE;
            RUNNING <= 1'b0;
          end else if (prescaler == PS_MAX) begin
            prescaler  <= '0;
            CNT_ENABLE <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        PAUSE: begin
          if (clr_edge) begin
            state     <= IDLE;
            prescaler <= '0;
            CNT_RESET <= 1'b1;
          end else if (start_edge) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end
        end
        DONE: begin
          if (clr_edge) begin
            state     <= IDLE;
            EXPIRED   <= 1'b0;
            prescaler <= '0;
            CNT_RESET <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - directed self-checking bench for stopwatch_controller
module tb_stopwatch_controller;

  logic       CLK;
  logic       RESET;
  logic       BTN_START_STOP;
  logic       BTN_CLEAR;
  logic       MODE_DOWN;
  logic       ZERO_DETECT;
  logic       CHAIN_TRIG;
  logic       CNT_ENABLE;
  logic       CNT_RESET;
  logic       CNT_DIR;
  logic       RUNNING;
  logic       EXPIRED;
  logic [1:0] STATE;

  int n_vec;
  int n_err;
  int ticks;

  stopwatch_controller #(
    .PRESCALE_MAX   (3),
    .PRESCALE_WIDTH (2)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BTN_START_STOP (BTN_START_STOP),
    .BTN_CLEAR      (BTN_CLEAR),
    .MODE_DOWN      (MODE_DOWN),
    .ZERO_DETECT    (ZERO_DETECT),
    .CHAIN_TRIG     (CHAIN_TRIG),
    .CNT_ENABLE     (CNT_ENABLE),
    .CNT_RESET      (CNT_RESET),
    .CNT_DIR        (CNT_DIR),
    .RUNNING        (RUNNING),
    .EXPIRED        (EXPIRED),
    .STATE          (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Returns just after the edge on which the FSM acts on the synchronized edge.
  task automatic press(input logic s, input logic c);
    BTN_START_STOP = s;
    BTN_CLEAR      = c;
    step();
    step();
    BTN_START_STOP = 1'b0;
    BTN_CLEAR      = 1'b0;
    step();
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    BTN_START_STOP = 1'b0;
    BTN_CLEAR = 1'b0;
    MODE_DOWN = 1'b0;
    ZERO_DETECT = 1'b0;
    CHAIN_TRIG = 1'b0;
    repeat (3) step();

    chk("rst_state", STATE, 0);
    chk("rst_cnt_reset", CNT_RESET, 1);
    chk("rst_cnt_enable", CNT_ENABLE, 0);
    chk("rst_cnt_dir", CNT_DIR, 0);
    chk("rst_running", RUNNING, 0);
    chk("rst_expired", EXPIRED, 0);

    RESET = 1'b0;
    step();
    chk("post_rst_cnt_reset", CNT_RESET, 0);

    // Up-count run: ticks every 4 cycles starting 4 cycles after RUN entry.
    press(1'b1, 1'b0);
    chk("run_state", STATE, 1);
    chk("run_running", RUNNING, 1);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk("run_tick", CNT_ENABLE, (i % 4 == 0) ? 1 : 0);
      chk("run_no_reset", CNT_RESET, 0);
    end

    // Pause lands with the prescaler at 2 and must issue nothing while paused.
    press(1'b1, 1'b0);
    chk("pause_state", STATE, 2);
    chk("pause_running", RUNNING, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (CNT_ENABLE) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    press(1'b1, 1'b0);
    chk("resume_state", STATE, 1);
    chk("resume_tick0", CNT_ENABLE, 0);
    step();
    chk("resume_tick1", CNT_ENABLE, 0);
    step();
    chk("resume_tick2", CNT_ENABLE, 1);

    press(1'b0, 1'b1);
    chk("clr_run_state", STATE, 0);
    chk("clr_run_reset", CNT_RESET, 1);
    step();
    chk("clr_run_reset_end", CNT_RESET, 0);

    // Direction change in IDLE reloads the chain once.
    MODE_DOWN = 1'b1;
    step();
    chk("dir_update", CNT_DIR, 1);
    chk("dir_reset_pulse", CNT_RESET, 1);
    step();
    chk("dir_reset_end", CNT_RESET, 0);

    press(1'b1, 1'b0);
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (CNT_ENABLE) ticks++;
    end
    chk("down_ticks", ticks, 3);
    chk("down_tick3", CNT_ENABLE, 1);
    ZERO_DETECT = 1'b1;
    step();
    chk("down_done_state", STATE, 3);
    chk("down_expired", EXPIRED, 1);
    chk("down_running", RUNNING, 0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (CNT_ENABLE) ticks++;
    end
    chk("down_no_4th_tick", ticks, 0);
    ZERO_DETECT = 1'b0;
    press(1'b0, 1'b1);
    chk("down_clr_state", STATE, 0);
    MODE_DOWN = 1'b0;
    step();
    step();
    chk("up_dir", CNT_DIR, 0);

    // Up mode terminal on CHAIN_TRIG; DONE ignores start, leaves on clear.
    press(1'b1, 1'b0);
    repeat (4) step();
    chk("up_tick", CNT_ENABLE, 1);
    CHAIN_TRIG = 1'b1;
    step();
    CHAIN_TRIG = 1'b0;
    chk("up_done_state", STATE, 3);
    chk("up_expired", EXPIRED, 1);
    press(1'b1, 1'b0);
    chk("done_start_ignored", STATE, 3);
    chk("done_still_expired", EXPIRED, 1);
    press(1'b0, 1'b1);
    chk("done_clr_state", STATE, 0);
    chk("done_clr_reset", CNT_RESET, 1);
    chk("done_clr_expired", EXPIRED, 0);
    step();
    chk("done_clr_reset_end", CNT_RESET, 0);

    // Simultaneous start and clear act as clear.
    press(1'b1, 1'b0);
    chk("both_pre_state", STATE, 1);
    press(1'b1, 1'b1);
    chk("both_state", STATE, 0);
    chk("both_reset", CNT_RESET, 1);
    chk("both_running", RUNNING, 0);
    step();
    chk("both_reset_end", CNT_RESET, 0);

    // RESET mid-run with prescaler at 2.
    press(1'b1, 1'b0);
    step();
    step();
    RESET = 1'b1;
    step();
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_enable", CNT_ENABLE, 0);
    chk("mid_rst_reset", CNT_RESET, 1);
    RESET = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (CNT_ENABLE) ticks++;
    end
    chk("mid_rst_no_tick", ticks, 0);
    chk("mid_rst_idle", STATE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
